// File: rtl/joy_serializer_neptuno.sv
// Device-side model of the Neptuno joystick shift-register chain.
// Two active-low 12-button states (MXYZ SACB UDLR) are presented as a 16-bit
// frame shifted out MSB-first on joy_data_o. Each port can emulate the Sega
// 6-button phase sequence driven by the shared select strobe.
module joy_serializer_neptuno #(
    parameter int SIX_BUTTON  = 1,
    parameter int TIMEOUT     = 75000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] joy1_btn_i,
    input  logic [11:0] joy2_btn_i,
    input  logic        joy_clk_i,
    input  logic        joy_load_i,
    input  logic        sega_sel_i,
    output logic        joy_data_o,
    output logic [1:0]  phase_o,
    output logic [4:0]  bits_shifted_o
);

    localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    // Six pin lines {U,D,L,R,F1,F2} a Sega pad drives for a given select level and phase.
    function automatic logic [5:0] pin_lines(input logic [11:0] b, input logic sel,
                                             input logic [1:0] ph);
        logic [5:0] r;
        if (sel) begin
            if (ph == 2'd3) begin
                r = {b[8], b[9], b[10], b[11], b[4], b[5]};   // Z Y X M B C
            end else begin
                r = {b[3], b[2], b[1], b[0], b[4], b[5]};     // U D L R B C
            end
        end else begin
            case (ph)
                2'd2:    r = {4'b0000, b[6], b[7]};           // 6-button signature
                2'd3:    r = {4'b1111, b[6], b[7]};
                default: r = {b[3], b[2], 2'b00, b[6], b[7]}; // U D 0 0 A S
            endcase
        end
        return r;
    endfunction

    // Bit 0 = joy_clk, bit 1 = joy_load, bit 2 = sega_sel
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  prev_q;
    logic [2:0]                  synced_s;

    logic           clk_rise_s;
    logic           load_active_s;
    logic           sel_s;
    logic           sel_edge_s;
    logic           sel_rise_s;
    logic [15:0]    frame_s;

    logic [15:0]    sr_q;
    logic [4:0]     cnt_q;
    logic [1:0]     phase_q;
    logic [TW-1:0]  to_q;

    // Edge detection and current frame assembly from synchronized inputs.
    always_comb begin
        synced_s      = sync_q[SYNC_STAGES-1];
        clk_rise_s    = synced_s[0] & ~prev_q[0];
        // A load that has only just risen still counts as asserted this cycle,
        // so a coincident clock rise is swallowed rather than shifted.
        load_active_s = ~synced_s[1] | ~prev_q[1];
        sel_s         = synced_s[2];
        sel_edge_s    = synced_s[2] ^ prev_q[2];
        sel_rise_s    = synced_s[2] & ~prev_q[2];
        frame_s       = {pin_lines(joy1_btn_i, sel_s, phase_q), 2'b11,
                         pin_lines(joy2_btn_i, sel_s, phase_q), 2'b11};
    end

    // Input synchronizers plus one extra copy for edge detection; preset high out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{3'b111}};
            prev_q <= 3'b111;
        end else begin
            sync_q[0] <= {sega_sel_i, joy_load_i, joy_clk_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= synced_s;
        end
    end

    // Sega phase counter with select-idle timeout; a select edge beats expiry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= 2'd0;
            to_q    <= '0;
        end else if (sel_edge_s) begin
            to_q <= '0;
            if ((SIX_BUTTON != 0) && sel_rise_s && (phase_q != 2'd3)) begin
                phase_q <= phase_q + 2'd1;
            end else begin
                phase_q <= phase_q;
            end
        end else if (to_q == TO_LAST) begin
            phase_q <= 2'd0;
            to_q    <= to_q;
        end else begin
            to_q    <= to_q + TW'(1);
        end
    end

    // Shift register: transparent load while load is asserted, else shift on clock rise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q  <= 16'hFFFF;
            cnt_q <= 5'd0;
        end else if (load_active_s) begin
            sr_q  <= frame_s;
            cnt_q <= 5'd0;
        end else if (clk_rise_s) begin
            sr_q <= {sr_q[14:0], 1'b1};
            if (cnt_q != 5'd16) begin
                cnt_q <= cnt_q + 5'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end else begin
            sr_q  <= sr_q;
            cnt_q <= cnt_q;
        end
    end

    assign joy_data_o     = sr_q[15];
    assign phase_o        = phase_q;
    assign bits_shifted_o = cnt_q;

endmodule

// File: tb/tb_joy_serializer_neptuno.sv
// Scoreboard bench for joy_serializer_neptuno: a 6-button and a 3-button
// instance share all inputs; expected serial bits come from a table-driven
// pad model and are popped by a monitor each time the shift count advances.
module tb_joy_serializer_neptuno;

    localparam int TO = 1000;   // shortened select timeout
    localparam int HP = 10;     // joy_clk half period in clk cycles
    localparam int SG = 20;     // select strobe spacing in clk cycles

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [11:0] joy1_btn = 12'hFFF;
    logic [11:0] joy2_btn = 12'hFFF;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        sega_sel = 1'b1;
    logic        data_a, data_b;
    logic [1:0]  phase_a, phase_b;
    logic [4:0]  bits_a, bits_b;

    typedef struct {
        int   n;
        logic a;
        logic b;
        int   ph;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_phase = 0;
    logic [4:0] prev_bits = 5'd0;

    always #5 clk = ~clk;

    joy_serializer_neptuno #(.SIX_BUTTON(1), .TIMEOUT(TO), .SYNC_STAGES(2)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .joy1_btn_i(joy1_btn), .joy2_btn_i(joy2_btn),
        .joy_clk_i(joy_clk), .joy_load_i(joy_load), .sega_sel_i(sega_sel),
        .joy_data_o(data_a), .phase_o(phase_a), .bits_shifted_o(bits_a));

    joy_serializer_neptuno #(.SIX_BUTTON(0), .TIMEOUT(TO), .SYNC_STAGES(2)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .joy1_btn_i(joy1_btn), .joy2_btn_i(joy2_btn),
        .joy_clk_i(joy_clk), .joy_load_i(joy_load), .sega_sel_i(sega_sel),
        .joy_data_o(data_b), .phase_o(phase_b), .bits_shifted_o(bits_b));

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Pad model: each line names the button bit it shows, or -1 (driven low) / -2 (driven high).
    function automatic logic [7:0] port_byte(input logic [11:0] b, input logic sel, input int ph);
        int         src[6];
        logic [7:0] r;
        if (sel && ph == 3)      src = '{8, 9, 10, 11, 4, 5};
        else if (sel)            src = '{3, 2, 1, 0, 4, 5};
        else if (ph == 3)        src = '{-2, -2, -2, -2, 6, 7};
        else if (ph == 2)        src = '{-1, -1, -1, -1, 6, 7};
        else                     src = '{3, 2, -1, -1, 6, 7};
        for (int k = 0; k < 6; k++) begin
            if (src[k] == -1)      r[7-k] = 1'b0;
            else if (src[k] == -2) r[7-k] = 1'b1;
            else                   r[7-k] = b[src[k]];
        end
        r[1:0] = 2'b11;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic v);
        if (v && !sega_sel && exp_phase < 3) exp_phase++;
        sega_sel = v;
        tick(SG);
    endtask

    task automatic run_frame(input logic [11:0] b1, input logic [11:0] b2, input int npulse);
        logic [15:0] fa, fb;
        exp_t        e;
        joy1_btn = b1;
        joy2_btn = b2;
        tick(2);
        fa = {port_byte(b1, sega_sel, exp_phase), port_byte(b2, sega_sel, exp_phase)};
        fb = {port_byte(b1, sega_sel, 0), port_byte(b2, sega_sel, 0)};
        joy_load = 1'b0;
        tick(6);
        joy_load = 1'b1;
        tick(6);
        check("first_bit_a", data_a, fa[15]);
        check("first_bit_b", data_b, fb[15]);
        check("bits_after_load", bits_a, 0);
        // buttons move mid-frame; the latched frame must not change
        joy1_btn = 12'($urandom);
        joy2_btn = 12'($urandom);
        for (int n = 1; n <= npulse && n <= 16; n++) begin
            e.n  = n;
            e.a  = (n < 16) ? fa[15-n] : 1'b1;
            e.b  = (n < 16) ? fb[15-n] : 1'b1;
            e.ph = exp_phase;
            q.push_back(e);
        end
        for (int n = 0; n < npulse; n++) begin
            joy_clk = 1'b1;
            tick(HP);
            joy_clk = 1'b0;
            tick(HP);
        end
        tick(4);
        check("bits_end", bits_a, (npulse > 16) ? 16 : npulse);
        if (npulse > 16) check("open_chain_end", data_a, 1);
        check("queue_drained", q.size(), 0);
    endtask

    // Monitor: every advance of the shift count is one serial bit to score.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_i && bits_a != prev_bits && bits_a != 5'd0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_shift: got count %0d, expected no shift", bits_a);
            end else begin
                e = q.pop_front();
                check("shift_count", bits_a, e.n);
                check("shift_count_b", bits_b, e.n);
                check("data_a", data_a, e.a);
                check("data_b", data_b, e.b);
                check("phase_a", phase_a, e.ph);
                check("phase_b", phase_b, 0);
            end
        end
        prev_bits <= bits_a;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] fa;
        exp_t        e;

        // Reset with arbitrary inputs
        joy1_btn = 12'($urandom);
        joy2_btn = 12'($urandom);
        joy_clk  = 1'($urandom);
        joy_load = 1'($urandom);
        sega_sel = 1'b1;
        reset_i  = 1'b1;
        tick(3);
        check("reset_data", data_a, 1);
        check("reset_phase", phase_a, 0);
        check("reset_bits", bits_a, 0);
        reset_i  = 1'b0;
        joy_clk  = 1'b0;
        joy_load = 1'b1;
        exp_phase = 0;
        tick(10);

        // Basic frame, R pressed on port 1, with a 17th pulse
        run_frame(12'hFFE, 12'hFFF, 17);

        // 3-button low phase, A pressed on port 1
        set_sel(1'b0);
        run_frame(12'hFBF, 12'($urandom), 16);

        // 6-button sequence with X pressed on port 1
        set_sel(1'b1);
        check("seq_phase1", phase_a, 1);
        set_sel(1'b0);
        set_sel(1'b1);
        check("seq_phase2", phase_a, 2);
        set_sel(1'b0);
        run_frame(12'hBFF, 12'($urandom), 16);
        set_sel(1'b1);
        check("seq_phase3", phase_a, 3);
        check("seq_phase_3btn", phase_b, 0);
        run_frame(12'hBFF, 12'($urandom), 16);
        set_sel(1'b0);

        // Timeout: phase stays 3 until exactly TIMEOUT cycles after the synced edge
        sega_sel = 1'b1;
        tick(TO + 2);
        check("timeout_before", phase_a, 3);
        tick(1);
        check("timeout_expired", phase_a, 0);
        check("timeout_3btn", phase_b, 0);
        exp_phase = 0;

        // Randomized frames across phases and select levels
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(TO + 20);
                exp_phase = 0;
            end
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                set_sel(1'b1);
                set_sel(1'b0);
            end
            if ($urandom_range(0, 1) == 1) set_sel(1'b1);
            run_frame(12'($urandom), 12'($urandom), 16);
        end

        // Load release coincident with clock rise, then reset after 5 shifts
        joy1_btn = 12'($urandom);
        joy2_btn = 12'($urandom);
        tick(2);
        fa = {port_byte(joy1_btn, sega_sel, exp_phase), port_byte(joy2_btn, sega_sel, exp_phase)};
        joy_load = 1'b0;
        tick(6);
        joy_load = 1'b1;
        joy_clk  = 1'b1;
        tick(6);
        check("collision_bits", bits_a, 0);
        check("collision_data", data_a, fa[15]);
        joy_clk = 1'b0;
        tick(HP);
        for (int n = 1; n <= 5; n++) begin
            e.n  = n;
            e.a  = fa[15-n];
            e.b  = data_b;
            e.ph = exp_phase;
            q.push_back(e);
        end
        // 3-button instance frame for the same buttons
        fa = {port_byte(joy1_btn, sega_sel, 0), port_byte(joy2_btn, sega_sel, 0)};
        for (int n = 0; n < 5; n++) q[n].b = fa[14-n];
        for (int n = 0; n < 5; n++) begin
            joy_clk = 1'b1;
            tick(HP);
            joy_clk = 1'b0;
            tick(HP);
        end
        check("pre_reset_bits", bits_a, 5);
        reset_i = 1'b1;
        tick(1);
        check("midframe_reset_data", data_a, 1);
        check("midframe_reset_bits", bits_a, 0);
        reset_i = 1'b0;
        exp_phase = 0;
        tick(5);
        check("queue_final", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
